// File: rtl/byte_bit_serializer.sv
// byte_bit_serializer
// Purpose: takes bytes from a ready/valid source, queues them in a small
// FIFO and replays them one bit per clock toward a serial CRC stage. Frame
// boundaries travel with each byte so the downstream stage gets a bit stream
// with no gaps inside a frame, plus sof/axiol markers on the first and last bits.
//
// Ports:
//   clk    in   1  system clock, rising edge
//   rst_n  in   1  asynchronous reset, active-low
//   axiiv  in   1  input byte valid
//   axiid  in   8  input byte
//   axiil  in   1  input byte closes its frame (qualified by axiiv)
//   axiir  out  1  ready, registered; high while the FIFO has a free entry
//   axiov  out  1  output bit valid
//   axiod  out  1  output bit
//   axiol  out  1  last bit of the frame (qualified by axiov)
//   sof    out  1  pulse on the first bit of every frame
//
// Build option: define SER_IFG_EN to insert IFG_BITS idle cycles after each
// frame. Without it the next frame may follow the last bit directly.

module byte_bit_serializer #(
    parameter int FIFO_DEPTH = 2,
    parameter int MSB_FIRST  = 1,
    parameter int IFG_BITS   = 96
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       axiiv,
    input  logic [7:0] axiid,
    input  logic       axiil,
    output logic       axiir,
    output logic       axiov,
    output logic       axiod,
    output logic       axiol,
    output logic       sof
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SHIFT = 2'd1;
    localparam logic [1:0] ST_STALL = 2'd2;
`ifdef SER_IFG_EN
    localparam logic [1:0] ST_GAP   = 2'd3;
    localparam int         GAP_W    = $clog2(IFG_BITS + 1);
`endif

    // FIFO entries hold {last, data}
    logic [8:0]       mem_q [FIFO_DEPTH];
    logic [8:0]       mem_d [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             axiir_q, axiir_d;

    logic [1:0]       state_q, state_d;
    logic [7:0]       shreg_q, shreg_d;
    logic [2:0]       bit_cnt_q, bit_cnt_d;
    logic             last_q, last_d;
    // sof_byte_q marks the byte in shreg as the first of a frame;
    // frame_start_q says the next popped byte opens a new frame
    logic             sof_byte_q, sof_byte_d;
    logic             frame_start_q, frame_start_d;
`ifdef SER_IFG_EN
    logic [GAP_W-1:0] gap_cnt_q, gap_cnt_d;
`endif

    logic             push;
    logic             pop;
    logic             fifo_empty;
    logic [8:0]       head;

    assign push       = axiiv && axiir_q;
    assign fifo_empty = (count_q == '0);
    assign head       = mem_q[rd_ptr_q];

    always_comb begin
        state_d       = state_q;
        shreg_d       = shreg_q;
        bit_cnt_d     = bit_cnt_q;
        last_d        = last_q;
        sof_byte_d    = sof_byte_q;
        frame_start_d = frame_start_q;
        pop           = 1'b0;
`ifdef SER_IFG_EN
        gap_cnt_d     = gap_cnt_q;
`endif

        case (state_q)
            ST_IDLE: begin
                if (!fifo_empty) begin
                    pop     = 1'b1;
                    state_d = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                bit_cnt_d = bit_cnt_q + 3'd1;
                shreg_d   = (MSB_FIRST != 0) ? {shreg_q[6:0], 1'b0} : {1'b0, shreg_q[7:1]};
                if (bit_cnt_q == 3'd7) begin
                    if (last_q) begin
                        frame_start_d = 1'b1;
`ifdef SER_IFG_EN
                        gap_cnt_d = '0;
                        state_d   = ST_GAP;
`else
                        // chain straight into the next frame when one is waiting
                        if (!fifo_empty) begin
                            pop = 1'b1;
                        end else begin
                            state_d = ST_IDLE;
                        end
`endif
                    end else if (!fifo_empty) begin
                        pop = 1'b1;
                    end else begin
                        state_d = ST_STALL;
                    end
                end
            end
            ST_STALL: begin
                if (!fifo_empty) begin
                    pop     = 1'b1;
                    state_d = ST_SHIFT;
                end
            end
`ifdef SER_IFG_EN
            ST_GAP: begin
                gap_cnt_d = gap_cnt_q + GAP_W'(1);
                // popping on the final gap cycle keeps the idle run at exactly IFG_BITS
                if (gap_cnt_q == GAP_W'(IFG_BITS - 1)) begin
                    if (!fifo_empty) begin
                        pop     = 1'b1;
                        state_d = ST_SHIFT;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
`endif
            default: state_d = ST_IDLE;
        endcase

        if (pop) begin
            shreg_d       = head[7:0];
            last_d        = head[8];
            bit_cnt_d     = 3'd0;
            sof_byte_d    = frame_start_d;
            frame_start_d = 1'b0;
        end
    end

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            mem_d[wr_ptr_q] = {axiil, axiid};
            wr_ptr_d        = wr_ptr_q + PTR_W'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        if (push && !pop) begin
            count_d = count_q + CNT_W'(1);
        end else if (pop && !push) begin
            count_d = count_q - CNT_W'(1);
        end
        axiir_d = (count_d != CNT_W'(FIFO_DEPTH));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            count_q       <= '0;
            axiir_q       <= 1'b0;
            state_q       <= ST_IDLE;
            shreg_q       <= '0;
            bit_cnt_q     <= '0;
            last_q        <= 1'b0;
            sof_byte_q    <= 1'b0;
            frame_start_q <= 1'b1;
`ifdef SER_IFG_EN
            gap_cnt_q     <= '0;
`endif
        end else begin
            mem_q         <= mem_d;
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            count_q       <= count_d;
            axiir_q       <= axiir_d;
            state_q       <= state_d;
            shreg_q       <= shreg_d;
            bit_cnt_q     <= bit_cnt_d;
            last_q        <= last_d;
            sof_byte_q    <= sof_byte_d;
            frame_start_q <= frame_start_d;
`ifdef SER_IFG_EN
            gap_cnt_q     <= gap_cnt_d;
`endif
        end
    end

    assign axiir = axiir_q;
    assign axiov = (state_q == ST_SHIFT);
    assign axiod = axiov && ((MSB_FIRST != 0) ? shreg_q[7] : shreg_q[0]);
    assign axiol = axiov && (bit_cnt_q == 3'd7) && last_q;
    assign sof   = axiov && (bit_cnt_q == 3'd0) && sof_byte_q;

endmodule

// File: tb/tb_byte_bit_serializer.sv
// Testbench for byte_bit_serializer (default parameters, MSB first).
// Expected bits are queued when a byte is accepted and popped by a monitor
// that samples the DUT on the falling clock edge.

module tb_byte_bit_serializer;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       axiiv = 1'b0;
    logic [7:0] axiid = 8'h00;
    logic       axiil = 1'b0;
    logic       axiir, axiov, axiod, axiol, sof;

    byte_bit_serializer dut (
        .clk   (clk),
        .rst_n (rst_n),
        .axiiv (axiiv),
        .axiid (axiid),
        .axiil (axiil),
        .axiir (axiir),
        .axiov (axiov),
        .axiod (axiod),
        .axiol (axiol),
        .sof   (sof)
    );

    always #5 clk = ~clk;

`ifdef SER_IFG_EN
    localparam int GAP_EXP = 96;
`else
    localparam int GAP_EXP = 0;
`endif

    typedef struct packed {
        logic sof_e;
        logic bit_e;
        logic last_e;
    } exp_t;

    exp_t        exp_q[$];
    int          checks = 0;
    int          failures = 0;
    logic        frame_start_m = 1'b1;
    bit          saw_full = 1'b0;

    int          rx_count = 0;
    int          frame_len = 0;
    int          last_len = 0;
    bit          contig = 1'b0;
    bit          last_contig = 1'b0;
    logic [31:0] crc = 32'hFFFF_FFFF;
    logic [31:0] last_crc = 32'h0;
    int          idle_run = 0;
    int          last_gap = -1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    // Monitor: score every valid bit and track frame length, continuity, CRC, gap
    always @(negedge clk) begin
        if (rst_n) begin
            if (axiov) begin
                exp_t e;
                logic fb;
                check("scoreboard_nonempty", 32'(exp_q.size() != 0), 32'd1);
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    check("axiod", 32'(axiod), 32'(e.bit_e));
                    check("sof", 32'(sof), 32'(e.sof_e));
                    check("axiol", 32'(axiol), 32'(e.last_e));
                end
                rx_count++;
                if (sof) begin
                    frame_len = 0;
                    contig    = 1'b1;
                    crc       = 32'hFFFF_FFFF;
                    last_gap  = idle_run;
                end
                frame_len++;
                fb  = crc[31] ^ axiod;
                crc = {crc[30:0], 1'b0} ^ (fb ? 32'h04C1_1DB7 : 32'h0);
                idle_run = 0;
                if (axiol) begin
                    last_len    = frame_len;
                    last_contig = contig;
                    last_crc    = crc;
                end
            end else begin
                check("idle_markers", {30'd0, sof, axiol}, 32'd0);
                contig = 1'b0;
                idle_run++;
            end
        end
    end

    task automatic applyStimulus(input logic [7:0] d, input logic l);
        int waited = 0;
        @(negedge clk);
        axiiv = 1'b1;
        axiid = d;
        axiil = l;
        while (!axiir && waited < 200) begin
            saw_full = 1'b1;
            @(negedge clk);
            waited++;
        end
        if (!axiir) begin
            check("accept_timeout", 32'(axiir), 32'd1);
        end else begin
            @(posedge clk);
            for (int i = 0; i < 8; i++) begin
                exp_t e;
                e.bit_e  = d[7-i];
                e.sof_e  = (i == 0) && frame_start_m;
                e.last_e = (i == 7) && l;
                exp_q.push_back(e);
            end
            frame_start_m = l;
        end
    endtask

    task automatic stopDriving();
        @(negedge clk);
        axiiv = 1'b0;
        axiil = 1'b0;
    endtask

    task automatic checkOutput();
        int n = 0;
        while (exp_q.size() != 0 && n < 2000) begin
            @(negedge clk);
            n++;
        end
        check("drain", 32'(exp_q.size()), 32'd0);
        repeat (3) @(negedge clk);
    endtask

    initial begin
        logic [7:0] frame8 [8];
        int base;
        bit found;
        frame8 = '{8'hce, 8'h2e, 8'h88, 8'hd9, 8'hb8, 8'hbc, 8'h75, 8'hde};

        // Reset held for 3 cycles
        repeat (3) @(negedge clk);
        check("rst_axiov", 32'(axiov), 32'd0);
        check("rst_axiir", 32'(axiir), 32'd0);
        check("rst_sof", 32'(sof), 32'd0);
        check("rst_axiol", 32'(axiol), 32'd0);
        rst_n = 1'b1;
        #1 check("axiir_before_edge", 32'(axiir), 32'd0);
        @(posedge clk);
        #1 check("axiir_after_release", 32'(axiir), 32'd1);

        // Single byte frame with two-cycle latency
        applyStimulus(8'hCE, 1'b1);
        #1 check("latency_cycle1_axiov", 32'(axiov), 32'd0);
        @(negedge clk);
        axiiv = 1'b0;
        axiil = 1'b0;
        @(posedge clk);
        #1 check("latency_cycle2_axiov", 32'(axiov), 32'd1);
        check("latency_cycle2_sof", 32'(sof), 32'd1);
        checkOutput();
        check("single_len", 32'(last_len), 32'd8);

        // Eight-byte frame, contiguous bits and CRC
        for (int i = 0; i < 8; i++) applyStimulus(frame8[i], i == 7);
        stopDriving();
        checkOutput();
        check("frame8_len", 32'(last_len), 32'd64);
        check("frame8_contig", 32'(last_contig), 32'd1);
        check("frame8_crc", last_crc, 32'h0DA2_57ED);

        // Underrun between two bytes of one frame
        applyStimulus(8'hA5, 1'b0);
        stopDriving();
        repeat (20) @(negedge clk);
        check("stall_axiov", 32'(axiov), 32'd0);
        applyStimulus(8'h3C, 1'b1);
        stopDriving();
        checkOutput();
        check("underrun_len", 32'(last_len), 32'd16);
        check("underrun_contig", 32'(last_contig), 32'd0);

        // Continuous feed of 16 bytes to fill the FIFO
        saw_full = 1'b0;
        for (int i = 0; i < 16; i++) applyStimulus(8'($urandom_range(0, 255)), i == 15);
        stopDriving();
        checkOutput();
        check("full_ready_dropped", 32'(saw_full), 32'd1);
        check("full_len", 32'(last_len), 32'd128);
        check("full_contig", 32'(last_contig), 32'd1);

        // Two one-byte frames queued together
        applyStimulus(8'h81, 1'b1);
        applyStimulus(8'h7E, 1'b1);
        stopDriving();
        checkOutput();
        check("interframe_gap", 32'(last_gap), 32'(GAP_EXP));

        // Reset at bit 3 of the second byte of a frame
        base = rx_count;
        found = 1'b0;
        applyStimulus(8'h11, 1'b0);
        applyStimulus(8'h22, 1'b0);
        applyStimulus(8'h33, 1'b1);
        stopDriving();
        for (int n = 0; n < 200 && !found; n++) begin
            @(posedge clk);
            #1;
            if (axiov && (rx_count - base) == 11) found = 1'b1;
        end
        check("midframe_reached", 32'(found), 32'd1);
        rst_n = 1'b0;
        #1;
        check("midrst_axiov", 32'(axiov), 32'd0);
        check("midrst_axiol", 32'(axiol), 32'd0);
        check("midrst_sof", 32'(sof), 32'd0);
        check("midrst_axiir", 32'(axiir), 32'd0);
        exp_q.delete();
        frame_start_m = 1'b1;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        applyStimulus(8'h5A, 1'b1);
        stopDriving();
        checkOutput();
        check("post_reset_len", 32'(last_len), 32'd8);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
